// File: rtl/conv_tap_feeder.sv
// Convolution tap feeder: 9-entry weight file streamed against incoming pixels through a
// saturating multiplier, with one-cycle registered products and window framing flags.
module conv_tap_feeder (
   input  logic       clk,
   input  logic       rst,
   input  logic       w_load,
   input  logic [3:0] w_idx,
   input  logic [7:0] w_data,
   output logic       w_err,
   input  logic       pix_valid,
   input  logic [7:0] pix_data,
   output logic       pix_ready,
   output logic [7:0] prod_out,
   output logic       prod_valid,
   output logic       prod_first,
   output logic       win_done
);

   localparam int unsigned NumTaps = 9;

   typedef enum logic [1:0] {StIdle, StArmed, StStream} state_e;

   state_e               state_q, state_d;
   logic [7:0]           weight_q [NumTaps];
   logic [NumTaps-1:0]   mask_q, mask_d;
   logic [3:0]           tap_q, tap_d;
   logic                 hs;
   logic                 last_tap;
   logic                 w_accept;
   logic                 w_reject;
   logic [15:0]          product;

   // Writes are frozen while a window is in flight so a window never mixes weight sets.
   assign w_reject = w_load && ((w_idx > 4'd8) || (state_q == StStream));
   assign w_accept = w_load && !w_reject;
   assign last_tap = (tap_q == 4'd8);
   assign product  = 16'(pix_data) * 16'(weight_q[tap_q]);

   always_comb begin
      mask_d = mask_q;
      if (w_accept) begin
         mask_d[w_idx] = 1'b1;
      end
   end

   always_comb begin
      tap_d = tap_q;
      if (hs) begin
         tap_d = last_tap ? 4'd0 : tap_q + 4'd1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (&mask_d) state_d = StArmed;
         StArmed:  if (hs) state_d = StStream;
         StStream: if (hs && last_tap) state_d = StArmed;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      pix_ready = (state_q != StIdle);
      hs        = pix_valid && pix_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mask_q <= '0;
         tap_q  <= 4'd0;
         for (int i = 0; i < NumTaps; i++) begin
            weight_q[i] <= 8'h00;
         end
      end else begin
         mask_q <= mask_d;
         tap_q  <= tap_d;
         if (w_accept) begin
            weight_q[w_idx] <= w_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prod_out   <= 8'h00;
         prod_valid <= 1'b0;
         prod_first <= 1'b0;
         win_done   <= 1'b0;
         w_err      <= 1'b0;
      end else begin
         w_err <= w_reject;
         if (hs) begin
            prod_out   <= (product > 16'd255) ? 8'hFF : product[7:0];
            prod_valid <= 1'b1;
            prod_first <= (tap_q == 4'd0);
            win_done   <= last_tap;
         end else begin
            prod_valid <= 1'b0;
            prod_first <= 1'b0;
            win_done   <= 1'b0;
         end
      end
   end

endmodule

// File: doc/conv_tap_feeder.md
CONV_TAP_FEEDER -- requirements
Module: conv_tap_feeder

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- w_load  input  1  weight write strobe.
- w_idx  input  4  weight tap index, 0..8.
- w_data  input  8  unsigned weight value.
- w_err  output  1  one-cycle pulse: weight write rejected.
- pix_valid  input  1  pixel offered this cycle.
- pix_data  input  8  unsigned pixel value.
- pix_ready  output  1  block accepts a pixel this cycle.
- prod_out  output  8  saturated product; feeds the 8-bit accumulator input.
- prod_valid  output  1  prod_out holds a new product.
- prod_first  output  1  prod_out is tap 0 of a window.
- win_done  output  1  prod_out is tap 8 of a window.

REQ-002 The block SHALL have no parameters; tap count is fixed at 9, data width at 8.

Function
REQ-003 The block SHALL hold a 9-entry x 8-bit weight file and a 9-bit written-mask, one bit per tap.
REQ-004 A weight write SHALL be accepted when w_load=1, w_idx<=8 and state is not STREAM:
- weight[w_idx] <= w_data.
- mask bit w_idx set.
REQ-005 A weight write SHALL be rejected, with w_err pulsed high for exactly one cycle on the next edge and no state changed, when:
- w_idx>8, or
- w_load=1 while in STREAM.
REQ-006 The FSM SHALL have three states:
- IDLE: mask not all ones.
- ARMED: mask all ones, tap counter = 0.
- STREAM: tap counter 1..8.
REQ-007 FSM transitions SHALL be:
- IDLE->ARMED on the edge where the ninth distinct tap is written.
- ARMED->STREAM on a pixel handshake.
- STREAM->ARMED on the handshake at tap 8.
- No other transitions except reset.
REQ-008 pix_ready SHALL be 1 in ARMED and STREAM and 0 in IDLE; it is combinational from state only, never from pix_valid.
REQ-009 A handshake SHALL occur when pix_valid=1 and pix_ready=1 on a rising edge.
REQ-010 On each handshake the block SHALL:
- compute pix_data x weight[tap] as a 16-bit unsigned product;
- increment tap, wrapping 8->0.
REQ-011 Output latency SHALL be exactly one cycle: products are registered, and prod_valid is high in the cycle after the handshake only.
REQ-012 Saturation: prod_out SHALL be the 16-bit product when it is <=255, else 8'hFF.
REQ-013 Framing flags:
- prod_first=1 only with the product of tap 0.
- win_done=1 only with the product of tap 8.
- Both flags are 0 whenever prod_valid=0.
REQ-014 When prod_valid=0, prod_out SHALL hold its last value.
REQ-015 Back-to-back handshakes SHALL produce one product per cycle with no bubbles; window N+1 tap 0 may directly follow window N tap 8.
REQ-016 Pixel gaps (pix_valid=0) mid-window SHALL pause the tap counter without losing position.
REQ-017 Weight rewrites in ARMED SHALL take effect for the next window; the mask stays all ones.
REQ-018 A write with w_load=1 in the same cycle as the tap-8 handshake SHALL be rejected, because the state is still STREAM at that edge.

Reset
REQ-019 While rst=0 the block SHALL asynchronously force:
- state=IDLE, tap=0, mask=0;
- prod_out=8'h00, prod_valid=0, prod_first=0, win_done=0, w_err=0.
- The weight file is cleared to 0.
REQ-020 Reset asserted mid-window SHALL discard the partial window; after release no product is emitted until all 9 weights are rewritten.
REQ-021 After rst returns to 1, the first accepted action SHALL occur on the first subsequent rising edge.

Verification
REQ-022 Load weights 1..9 to taps 0..8, stream 9 pixels of value 2 -> prod_out 2,4,...,18; prod_first on the first product, win_done on the ninth; each appears 1 cycle after its handshake.
REQ-023 Weight 200 at tap 0, pixel 3 -> prod_out=8'hFF; pixel 1 -> prod_out=200.
REQ-024 Only 8 taps written -> pix_ready stays 0 and pix_valid is ignored; write tap 8 -> pix_ready=1 on the next cycle.
REQ-025 Write w_idx=9, and write any index after the tap-3 handshake -> w_err one-cycle pulse each time; the weights are unchanged.
REQ-026 Stream 18 pixels continuously with 2 idle cycles inserted after tap 4 -> two windows, correct flags, the tap position is held across the gap.
REQ-027 Drop rst to 0 after the tap-5 handshake -> all outputs 0 immediately; after release pix_ready=0 until 9 weights are rewritten.
